// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and
// buffers returned words in a small queue that feeds decode one per cycle.
module i_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                Q_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              stale_q, stale_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [31:0]       q_data_q [Q_DEPTH];
    logic [31:0]       q_data_d [Q_DEPTH];
    logic [ADDR_W-1:0] q_pc_q   [Q_DEPTH];
    logic [ADDR_W-1:0] q_pc_d   [Q_DEPTH];

    logic [2:0]        occ_s;
    logic              issue_s;
    logic              resp_s;
    logic              push_s;
    logic              pop_s;
    logic              valid_s;

    // Next-state logic: issue, response capture, queue push/pop, halt and redirect.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tag_pc_d      = tag_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        q_data_d      = q_data_q;
        q_pc_d        = q_pc_q;

        // Counting the in-flight word as occupied makes a push into a full queue impossible.
        occ_s   = {1'b0, count_q} + {2'b00, outstanding_q};
        valid_s = (count_q != 2'd0);
        issue_s = rst && (state_q == ST_RUN) && !redirect && !outstanding_q
                  && (occ_s < 3'(Q_DEPTH));
        resp_s  = imem_rvalid && outstanding_q;
        push_s  = resp_s && !stale_q && !redirect;
        pop_s   = valid_s && !hold && !redirect;

        if (redirect) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            pc_d     = redirect_pc & ~ADDR_W'(3);
            state_d  = ST_RUN;
            if (resp_s) begin
                outstanding_d = 1'b0;
                stale_d       = 1'b0;
            end else if (outstanding_q) begin
                stale_d = 1'b1;
            end else begin
                stale_d = stale_q;
            end
        end else begin
            if (resp_s) begin
                outstanding_d = 1'b0;
                stale_d       = 1'b0;
            end else if (issue_s) begin
                outstanding_d = 1'b1;
                pc_d          = pc_q + ADDR_W'(4);
                tag_pc_d      = pc_q;
            end else begin
                outstanding_d = outstanding_q;
            end

            if (push_s) begin
                q_data_d[wr_ptr_q] = imem_rdata;
                q_pc_d[wr_ptr_q]   = tag_pc_q;
                wr_ptr_d           = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // Output decode from the queue head and the request gate.
    always_comb begin
        imem_req    = issue_s;
        imem_addr   = issue_s ? pc_q : {ADDR_W{1'b0}};
        instr_valid = valid_s;
        instruction = valid_s ? q_data_q[rd_ptr_q] : 32'h0000_0000;
        instr_pc    = valid_s ? q_pc_q[rd_ptr_q] : {ADDR_W{1'b0}};
        halted      = (state_q == ST_HALTED);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            tag_pc_q      <= {ADDR_W{1'b0}};
            outstanding_q <= 1'b0;
            stale_q       <= 1'b0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_data_q[i] <= 32'h0000_0000;
                q_pc_q[i]   <= {ADDR_W{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tag_pc_q      <= tag_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            q_data_q      <= q_data_d;
            q_pc_q        <= q_pc_d;
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: a latency-programmable memory model feeds the main
// instance; a second instance with RESET_PC near the top checks PC wrap.
module tb_i_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        halted;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_rvalid_w;
    logic [31:0] imem_rdata_w = 32'h1234_5678;
    logic [31:0] instruction_w;
    logic        instr_valid_w;
    logic [31:0] instr_pc_w;
    logic        halted_w;

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    logic [31:0] popped [$];

    always #5 clk = ~clk;

    i_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .Q_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .hold(hold), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_pc(instr_pc), .halted(halted)
    );

    i_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .Q_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst), .hold(1'b0), .halt(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0000_0000), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w), .instruction(instruction_w),
        .instr_valid(instr_valid_w), .instr_pc(instr_pc_w), .halted(halted_w)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after posedge, then stop at the negedge for checking.
    task automatic next_cycle(input logic r, input logic h, input logic hl,
                              input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        hold        = h;
        halt        = hl;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Memory model: one request at a time, response 'lat' cycles after the request cycle.
    initial begin
        logic        m_busy;
        int          m_age;
        logic [31:0] m_addr;
        m_busy      = 1'b0;
        m_age       = 0;
        m_addr      = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_addr = imem_addr;
            end else if (imem_rvalid) begin
                m_busy = 1'b0;
            end
            @(posedge clk);
            #1;
            if (m_busy) begin
                m_age++;
                imem_rvalid = (m_age == lat);
                imem_rdata  = (m_age == lat) ? word_of(m_addr) : 32'h0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // One-cycle responder for the wrap instance.
    initial begin
        logic pend_w;
        imem_rvalid_w = 1'b0;
        forever begin
            @(negedge clk);
            pend_w = imem_req_w;
            @(posedge clk);
            #1;
            imem_rvalid_w = pend_w;
        end
    end

    // Log the PC of every word decode consumes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && instr_valid && !hold && !redirect) popped.push_back(instr_pc);
        end
    end

    initial begin
        rst = 1'b0; hold = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset state
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rst_req",   32'(imem_req), 32'd0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_pc",    instr_pc, 32'h0);
        check_eq("rst_halt",  32'(halted), 32'd0);

        // Start-up with 1-cycle memory, then hold for three cycles
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c0
        check_eq("c0_req",  32'(imem_req), 32'd1);
        check_eq("c0_addr", imem_addr, 32'h0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c1
        check_eq("c1_req",   32'(imem_req), 32'd0);
        check_eq("c1_valid", 32'(instr_valid), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c2
        check_eq("c2_valid", 32'(instr_valid), 32'd1);
        check_eq("c2_instr", instruction, word_of(32'h0));
        check_eq("c2_pc",    instr_pc, 32'h0);
        check_eq("c2_addr",  imem_addr, 32'h4);
        check_eq("wrap_valid", 32'(instr_valid_w), 32'd1);
        check_eq("wrap_pc",    instr_pc_w, 32'hFFFF_FFFC);
        check_eq("wrap_instr", instruction_w, 32'h1234_5678);
        check_eq("wrap_req",   32'(imem_req_w), 32'd1);
        check_eq("wrap_addr",  imem_addr_w, 32'h0000_0000);
        check_eq("wrap_halt",  32'(halted_w), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c3
        check_eq("c3_valid", 32'(instr_valid), 32'd0);
        next_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);                       // c4
        check_eq("c4_pc",   instr_pc, 32'h4);
        check_eq("c4_addr", imem_addr, 32'h8);
        next_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);                       // c5
        check_eq("c5_req", 32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);                       // c6: queue full
        check_eq("full_req",   32'(imem_req), 32'd0);
        check_eq("full_valid", 32'(instr_valid), 32'd1);
        check_eq("full_pc",    instr_pc, 32'h4);
        for (int i = 7; i <= 14; i++) next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("pop_count", 32'(popped.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check_eq($sformatf("pop_order%0d", i), popped[i], 32'(i * 4));

        // Redirect while a slow request is in flight: its response must be dropped
        do_reset();
        lat = 3;
        next_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010);               // c0
        check_eq("rd0_req", 32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c1
        check_eq("rd1_addr", imem_addr, 32'h10);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);               // c2
        check_eq("rd2_req", 32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c3
        check_eq("rd3_req", 32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c4: stale response
        check_eq("rd4_req", 32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c5
        check_eq("rd5_req",   32'(imem_req), 32'd1);
        check_eq("rd5_addr",  imem_addr, 32'h100);
        check_eq("rd5_valid", 32'(instr_valid), 32'd0);
        for (int i = 6; i <= 8; i++) next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rd8_valid", 32'(instr_valid), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c9
        check_eq("rd9_valid", 32'(instr_valid), 32'd1);
        check_eq("rd9_pc",    instr_pc, 32'h100);
        check_eq("rd9_instr", instruction, word_of(32'h100));

        // Halt at 0x20, drain, then redirect (with halt) to 0x40
        do_reset();
        lat = 1;
        next_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020);               // c0
        next_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);                       // c1
        check_eq("h1_addr", imem_addr, 32'h20);
        check_eq("h1_halt", 32'(halted), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c2
        check_eq("h2_halt", 32'(halted), 32'd1);
        check_eq("h2_req",  32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c3
        check_eq("h3_valid", 32'(instr_valid), 32'd1);
        check_eq("h3_pc",    instr_pc, 32'h20);
        check_eq("h3_req",   32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c4
        check_eq("h4_valid", 32'(instr_valid), 32'd0);
        check_eq("h4_req",   32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);               // c5
        check_eq("h5_req",  32'(imem_req), 32'd0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c6
        check_eq("h6_halt", 32'(halted), 32'd0);
        check_eq("h6_req",  32'(imem_req), 32'd1);
        check_eq("h6_addr", imem_addr, 32'h40);

        // Reset mid-stream with a request outstanding; straggler must be ignored
        do_reset();
        lat = 3;
        for (int i = 0; i <= 4; i++) next_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("m4_valid", 32'(instr_valid), 32'd1);
        check_eq("m4_addr",  imem_addr, 32'h4);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                       // c5
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);                       // c6
        check_eq("m6_req",   32'(imem_req), 32'd0);
        check_eq("m6_addr",  imem_addr, 32'h0);
        check_eq("m6_valid", 32'(instr_valid), 32'd0);
        check_eq("m6_instr", instruction, 32'h0);
        check_eq("m6_pc",    instr_pc, 32'h0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c7
        check_eq("m7_req",  32'(imem_req), 32'd1);
        check_eq("m7_addr", imem_addr, 32'h0);
        next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);                       // c8
        check_eq("m8_valid", 32'(instr_valid), 32'd0);
        for (int i = 9; i <= 11; i++) next_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("m11_valid", 32'(instr_valid), 32'd1);
        check_eq("m11_pc",    instr_pc, 32'h0);
        check_eq("m11_instr", instruction, word_of(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
